// File: rtl/aiva_pkg.sv
// Shared opcode constants and FSM state encoding for the instruction
// execution controller.
package aiva_pkg;

    localparam int unsigned OPC_NOP  = 0;
    localparam int unsigned OPC_LDI  = 1;
    localparam int unsigned OPC_JMP  = 2;
    localparam int unsigned OPC_WAIT = 3;
    // HALT is the all-ones opcode; it is matched by a reduction AND at the use site.

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_WAIT = 2'd2,
        ST_HALT = 2'd3
    } state_e;

endpackage

// File: rtl/exec_wait_cnt.sv
// Down-counter for WAIT instructions: loadable, decrements when enabled,
// saturates at zero, and flags when the count is exactly one.
module exec_wait_cnt #(
    parameter int unsigned CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [CNT_W-1:0] load_val,
    input  logic             en,
    output logic             is_one
);

    logic [CNT_W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load) begin
            cnt_d = load_val;
        end else if (en && (cnt_q != '0)) begin
            cnt_d = cnt_q - 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign is_one = (cnt_q == CNT_W'(1));

endmodule

// File: rtl/exec_ctrl.sv
// Instruction execution controller: latches an instruction word from fetch,
// sequences it through IDLE/EXEC/WAIT/HALT and raises registered strobes.
module exec_ctrl
    import aiva_pkg::*;
#(
    parameter int unsigned INSTR_W = 24,
    parameter int unsigned OPC_W   = 8,
    parameter int unsigned CNT_W   = 8,
    localparam int unsigned OPR_W  = INSTR_W - OPC_W
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               op_rdy,
    input  logic [INSTR_W-1:0] opcode_in,
    input  logic               resume,
    output logic               pc_en,
    output logic               pc_load,
    output logic [OPR_W-1:0]   pc_target,
    output logic               load_en,
    output logic [OPR_W-1:0]   load_data,
    output logic               done,
    output logic               halted,
    output logic               illegal
);

    state_e             state_q, state_d;
    logic [INSTR_W-1:0] instr_q, instr_d;
    logic               done_q, done_d;
    logic               load_en_q, load_en_d;
    logic               pc_load_q, pc_load_d;
    logic               illegal_q, illegal_d;
    logic               halted_q, halted_d;
    logic               cnt_load, cnt_en, cnt_is_one;

    logic [OPC_W-1:0]   opc_in, opc_d;
    logic [CNT_W-1:0]   wait_n_in;

    assign opc_in    = opcode_in[INSTR_W-1 -: OPC_W];
    assign wait_n_in = opcode_in[CNT_W-1:0];
    assign opc_d     = instr_d[INSTR_W-1 -: OPC_W];

    exec_wait_cnt #(
        .CNT_W (CNT_W)
    ) u_wait_cnt (
        .clk      (clk),
        .rst      (rst),
        .load     (cnt_load),
        .load_val (wait_n_in),
        .en       (cnt_en),
        .is_one   (cnt_is_one)
    );

    always_comb begin
        state_d  = state_q;
        instr_d  = instr_q;
        cnt_load = 1'b0;
        cnt_en   = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (op_rdy) begin
                    instr_d = opcode_in;
                    if ((opc_in == OPC_W'(OPC_WAIT)) && (wait_n_in != '0)) begin
                        state_d  = ST_WAIT;
                        cnt_load = 1'b1;
                    end else if (&opc_in) begin
                        state_d = ST_HALT;
                    end else begin
                        state_d = ST_EXEC;
                    end
                end
            end
            ST_EXEC: state_d = ST_IDLE;
            ST_WAIT: begin
                cnt_en = 1'b1;
                if (cnt_is_one) begin
                    state_d = ST_EXEC;
                end
            end
            ST_HALT: begin
                if (resume) begin
                    state_d = ST_EXEC;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Strobes are registered: decode the opcode that will be held during the
    // next cycle so each strobe coincides with the EXEC cycle.
    always_comb begin
        done_d    = (state_d == ST_EXEC);
        load_en_d = done_d && (opc_d == OPC_W'(OPC_LDI));
        pc_load_d = done_d && (opc_d == OPC_W'(OPC_JMP));
        illegal_d = done_d && (opc_d > OPC_W'(OPC_WAIT)) && !(&opc_d);
        halted_d  = (state_d == ST_HALT);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            instr_q   <= '0;
            done_q    <= 1'b0;
            load_en_q <= 1'b0;
            pc_load_q <= 1'b0;
            illegal_q <= 1'b0;
            halted_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            instr_q   <= instr_d;
            done_q    <= done_d;
            load_en_q <= load_en_d;
            pc_load_q <= pc_load_d;
            illegal_q <= illegal_d;
            halted_q  <= halted_d;
        end
    end

    assign done      = done_q;
    assign load_en   = load_en_q;
    assign pc_load   = pc_load_q;
    assign illegal   = illegal_q;
    assign halted    = halted_q;
    assign pc_target = instr_q[OPR_W-1:0];
    assign load_data = instr_q[OPR_W-1:0];
    assign pc_en     = done_q || ((state_q == ST_IDLE) && !op_rdy);

endmodule

// File: tb/tb_exec_ctrl.sv
// Self-checking bench for exec_ctrl: cycle model plus directed checks, and a
// wide-parameter instance for a long WAIT.
module tb_exec_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        op_rdy, resume;
    logic [23:0] opcode_in;
    logic        pc_en, pc_load, load_en, done, halted, illegal;
    logic [15:0] pc_target, load_data;

    logic        op_rdy2;
    logic [31:0] opcode_in2;
    logic        pc_en2, pc_load2, load_en2, done2, halted2, illegal2;
    logic [23:0] pc_target2, load_data2;

    int n_cmp = 0;
    int n_bad = 0;
    bit cmp_on = 1'b0;

    always #5 clk = ~clk;

    exec_ctrl dut (
        .clk(clk), .rst(rst), .op_rdy(op_rdy), .opcode_in(opcode_in), .resume(resume),
        .pc_en(pc_en), .pc_load(pc_load), .pc_target(pc_target), .load_en(load_en),
        .load_data(load_data), .done(done), .halted(halted), .illegal(illegal)
    );

    exec_ctrl #(.INSTR_W(32), .OPC_W(8), .CNT_W(16)) dut2 (
        .clk(clk), .rst(rst), .op_rdy(op_rdy2), .opcode_in(opcode_in2), .resume(1'b0),
        .pc_en(pc_en2), .pc_load(pc_load2), .pc_target(pc_target2), .load_en(load_en2),
        .load_data(load_data2), .done(done2), .halted(halted2), .illegal(illegal2)
    );

    // Behavioural model: remaining wait cycles, halt flag, retire-this-cycle flag.
    int          m_wait;
    bit          m_halt, m_retire;
    logic [23:0] m_instr;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_wait = 0; m_halt = 0; m_retire = 0; m_instr = '0;
        end else if (m_retire) begin
            m_retire = 0;
        end else if (m_halt) begin
            if (resume) begin m_halt = 0; m_retire = 1; end
        end else if (m_wait > 0) begin
            m_wait = m_wait - 1;
            if (m_wait == 0) m_retire = 1;
        end else if (op_rdy) begin
            m_instr = opcode_in;
            if (m_instr[23:16] == 8'h03 && m_instr[7:0] != 8'h00) m_wait = int'(m_instr[7:0]);
            else if (m_instr[23:16] == 8'hFF) m_halt = 1;
            else m_retire = 1;
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (cmp_on) begin
            logic [7:0] opc;
            bit         idle, legal;
            opc   = m_instr[23:16];
            idle  = !m_retire && !m_halt && (m_wait == 0);
            legal = (opc <= 8'h03) || (opc == 8'hFF);
            chk("m_done",      32'(done),      32'(m_retire));
            chk("m_load_en",   32'(load_en),   32'(m_retire && opc == 8'h01));
            chk("m_pc_load",   32'(pc_load),   32'(m_retire && opc == 8'h02));
            chk("m_illegal",   32'(illegal),   32'(m_retire && !legal));
            chk("m_halted",    32'(halted),    32'(m_halt));
            chk("m_pc_en",     32'(pc_en),     32'(m_retire || (idle && !op_rdy)));
            chk("m_pc_target", 32'(pc_target), 32'(m_instr[15:0]));
            chk("m_load_data", 32'(load_data), 32'(m_instr[15:0]));
        end
    end

    task automatic issue(input logic [23:0] w);
        @(posedge clk); #1;
        op_rdy = 1'b1; opcode_in = w;
        @(posedge clk); #1;
        op_rdy = 1'b0; opcode_in = 24'($urandom);
    endtask

    initial begin
        rst = 1'b1; op_rdy = 1'b0; resume = 1'b0; opcode_in = '0;
        op_rdy2 = 1'b0; opcode_in2 = '0;
        #1 cmp_on = 1'b1;
        @(negedge clk);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_halted", 32'(halted), 32'd0);
        chk("rst_pc_en_idle", 32'(pc_en), 32'd1);
        op_rdy = 1'b1;
        @(negedge clk);
        chk("rst_pc_en_rdy", 32'(pc_en), 32'd0);
        op_rdy = 1'b0;
        @(posedge clk); #1 rst = 1'b0;

        issue(24'h000000);
        @(negedge clk);
        chk("nop_done", 32'(done), 32'd1);
        chk("nop_pc_en", 32'(pc_en), 32'd1);

        issue(24'h01ABCD);
        @(negedge clk);
        chk("ldi_load_en", 32'(load_en), 32'd1);
        chk("ldi_data", 32'(load_data), 32'hABCD);
        @(negedge clk);
        chk("ldi_load_en_off", 32'(load_en), 32'd0);

        issue(24'h020042);
        @(negedge clk);
        chk("jmp_pc_load", 32'(pc_load), 32'd1);
        chk("jmp_target", 32'(pc_target), 32'h0042);
        @(negedge clk);
        chk("jmp_pc_load_off", 32'(pc_load), 32'd0);

        issue(24'h030005);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("wait5_pc_en", 32'(pc_en), 32'd0);
        end
        @(negedge clk);
        chk("wait5_done", 32'(done), 32'd1);

        issue(24'hFF0000);
        op_rdy = 1'b1; opcode_in = 24'h01FFFF;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            chk("halt_halted", 32'(halted), 32'd1);
            chk("halt_pc_en", 32'(pc_en), 32'd0);
        end
        op_rdy = 1'b0;
        @(posedge clk); #1 resume = 1'b1;
        @(posedge clk); #1 resume = 1'b0;
        @(negedge clk);
        chk("resume_done", 32'(done), 32'd1);
        chk("resume_halted", 32'(halted), 32'd0);

        @(posedge clk); #1 resume = 1'b1;
        @(posedge clk); #1 resume = 1'b0;

        issue(24'h7E1234);
        @(negedge clk);
        chk("ill_illegal", 32'(illegal), 32'd1);
        chk("ill_done", 32'(done), 32'd1);
        chk("ill_load_en", 32'(load_en), 32'd0);

        issue(24'h030000);
        @(negedge clk);
        chk("wait0_done", 32'(done), 32'd1);

        issue(24'h030001);
        issue(24'h015A5A);
        issue(24'h02FFFF);
        issue(24'hFE0001);
        issue(24'h040000);

        issue(24'h0300FF);
        repeat (10) @(posedge clk);
        #1 rst = 1'b1;
        #1;
        chk("rstw_done", 32'(done), 32'd0);
        chk("rstw_halted", 32'(halted), 32'd0);
        chk("rstw_load_en", 32'(load_en), 32'd0);
        chk("rstw_pc_en", 32'(pc_en), 32'd1);
        @(posedge clk); #1 rst = 1'b0;
        repeat (3) @(negedge clk);
        chk("rstw_no_done", 32'(done), 32'd0);
        issue(24'h01BEEF);
        @(negedge clk);
        chk("post_rst_ldi", 32'(load_data), 32'hBEEF);

        // Wide instance: WAIT 256 retires on the 257th cycle after the latch edge.
        @(posedge clk); #1;
        op_rdy2 = 1'b1; opcode_in2 = 32'h03000100;
        @(posedge clk); #1;
        op_rdy2 = 1'b0; opcode_in2 = '0;
        begin
            int k;
            k = 0;
            while (k < 400) begin
                @(negedge clk);
                k++;
                if (done2) break;
            end
            chk("w32_done_cycle", 32'(k), 32'd257);
        end
        chk("w32_data", 32'(load_data2), 32'h000100);

        repeat (3) @(posedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
